// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: parametrised width/depth, byte-lane writes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_lite_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BO = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = BO + IW;
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH + 1)'(DEPTH * NB);
  localparam logic [2:0] MAXSZ = 3'(BO);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [AW-1:0]         addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          accept, legal;
  logic [7:0]    amask;
  logic [NB-1:0] be;
  logic [IW-1:0] widx;
  logic          unused;

  assign unused = ^{HBURST, HPROT, HTRANS[0]};
  assign accept = HSEL & HREADY & HTRANS[1];
  assign amask  = (8'd1 << HSIZE) - 8'd1;
  assign legal  = ({1'b0, HADDR} < CAP) && (HSIZE <= MAXSZ) &&
                  ((HADDR[7:0] & amask) == 8'd0);

  // IDLE, DATA and ERR2 all end with HREADYOUT high, so they share the accept rules.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt <= 4'd1) begin
            state       <= S_DATA;
            hreadyout_q <= 1'b1;
          end
          cnt <= cnt - 4'd1;
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 2'b01;
        end
        default: begin
          if (accept) begin
            addr_q  <= HADDR[AW-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (!legal) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 2'b01;
            end else if (WAIT_STATES == 0) begin
              state       <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 2'b00;
            end else begin
              state       <= S_WAIT;
              cnt         <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
              hresp_q     <= 2'b00;
            end
          end else begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
          end
        end
      endcase
    end
  end

  // Accesses are aligned, so a lane belongs to the transfer when it sits in the same size-chunk.
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      be[i] = ((i >> size_q) == (int'(addr_q[BO-1:0]) >> size_q));
  end

  assign widx = addr_q[AW-1:BO];

  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[widx][i*8 +: 8] <= HWDATA[i*8 +: 8];
  end

  assign HRDATA    = (state == S_DATA && !write_q) ? mem[widx] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one zero-wait and one 2-wait instance, pipelined
// bus driver, directed vector tables, reset-in-wait sequence and random traffic vs a byte model.
module tb_ahb_lite_mem_slave;
  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  sz;
    bit [31:0] addr;
    bit [31:0] wdata;
  } op_t;

  typedef struct {
    bit [31:0] rd;
    bit [1:0]  resp;
    int        low;
    bit [1:0]  lowresp;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, dsel = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0, hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [31:0] rd0, rd1, rdata;
  logic        ro0, ro1, ready;
  logic [1:0]  rp0, rp1, resp;

  int total = 0, bad = 0;
  int ws [2] = '{0, 2};
  bit [7:0] refm [2][1024];
  op_t  ops [$];
  res_t got [$];
  res_t exp [$];
  vec_t tbl [$];

  always #5 HCLK = ~HCLK;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~dsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(ro0),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rp0));

  ahb_lite_mem_slave #(.WAIT_STATES(2)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & dsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(ro1),
    .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rp1));

  assign rdata = dsel ? rd1 : rd0;
  assign ready = dsel ? ro1 : ro0;
  assign resp  = dsel ? rp1 : rp0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, i, act, req);
    end
  endtask

  function automatic op_t mkop(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd);
    op_t o;
    o.sel = sel; o.trans = tr; o.wr = wr; o.sz = sz; o.addr = a; o.wdata = wd;
    return o;
  endfunction

  // Byte-addressed model: legality from the access rules, data by little-endian byte lanes.
  function automatic res_t model(int d, op_t o);
    res_t r;
    int a, a4;
    r.rd = '0; r.resp = 2'b00; r.low = 0; r.lowresp = 2'b00;
    if (!(o.sel && o.trans[1])) return r;
    if (o.addr >= 32'd1024 || o.sz > 3'd2 || (o.addr % (32'd1 << o.sz)) != 0) begin
      r.resp = 2'b01; r.low = 1; r.lowresp = 2'b01;
      return r;
    end
    r.low = ws[d];
    a  = int'(o.addr);
    a4 = a & ~3;
    if (o.wr) begin
      for (int b = 0; b < (1 << o.sz); b++)
        refm[d][a + b] = o.wdata[((a % 4) + b) * 8 +: 8];
    end else begin
      r.rd = {refm[d][a4 + 3], refm[d][a4 + 2], refm[d][a4 + 1], refm[d][a4]};
    end
    return r;
  endfunction

  task automatic vec(bit [1:0] tr, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd,
                     bit [31:0] erd, bit [1:0] eresp, int elow);
    vec_t v;
    v.op = mkop(1'b1, tr, wr, sz, a, wd);
    v.exp.rd = erd; v.exp.resp = eresp; v.exp.low = elow; v.exp.lowresp = eresp;
    tbl.push_back(v);
  endtask

  // Pipelined master: address phase of op n overlaps data phase of op n-1.
  task automatic run_ops(input logic d);
    int ai = 0, di = 0, cyc = 0;
    int n = ops.size();
    bit dv = 1'b0, rdy;
    res_t z;
    z.rd = '0; z.resp = 2'b00; z.low = 0; z.lowresp = 2'b00;
    dsel = d;
    got.delete();
    for (int i = 0; i < n; i++) got.push_back(z);
    forever begin
      if (ai < n) begin
        hsel = ops[ai].sel; htrans = ops[ai].trans; hwrite = ops[ai].wr;
        hsize = ops[ai].sz; haddr = ops[ai].addr;
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      hwdata = dv ? ops[di].wdata : 32'h0;
      @(negedge HCLK);
      rdy = ready;
      if (dv) begin
        if (!rdy) begin
          if (got[di].low == 0) got[di].lowresp = resp;
          got[di].low = got[di].low + 1;
        end else begin
          got[di].rd = rdata;
          got[di].resp = resp;
        end
      end
      @(posedge HCLK); #1;
      cyc++;
      if (cyc > 20 * n + 100) begin
        total++; bad++;
        $display("FAIL run_timeout got=%0d want<=%0d", cyc, 20 * n + 100);
        break;
      end
      if (rdy) begin
        dv = (ai < n);
        if (dv) begin di = ai; ai++; end
        else break;
      end
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < ops.size(); i++) begin
      chk({tag, "_rdata"}, i, got[i].rd, exp[i].rd);
      chk({tag, "_hresp"}, i, 32'(got[i].resp), 32'(exp[i].resp));
      chk({tag, "_lowcyc"}, i, got[i].low, exp[i].low);
      if (exp[i].low > 0) chk({tag, "_waitresp"}, i, 32'(got[i].lowresp), 32'(exp[i].lowresp));
    end
  endtask

  task automatic run_table(input logic d, input string tag);
    ops.delete(); exp.delete();
    for (int i = 0; i < tbl.size(); i++) begin
      ops.push_back(tbl[i].op);
      exp.push_back(tbl[i].exp);
      void'(model(int'(d), tbl[i].op));
    end
    run_ops(d);
    check_all(tag);
    tbl.delete();
  endtask

  task automatic run_model(input logic d, input string tag);
    exp.delete();
    for (int i = 0; i < ops.size(); i++) exp.push_back(model(int'(d), ops[i]));
    run_ops(d);
    check_all(tag);
  endtask

  function automatic op_t rnd_op();
    op_t o;
    int r;
    o.sel = ($urandom_range(0, 29) != 0);
    r = $urandom_range(0, 9);
    o.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
    o.wr = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 19);
    o.sz = (r == 0) ? 3'd3 : 3'(r % 3);
    o.addr = $urandom_range(0, 1023) & ~((32'd1 << o.sz) - 32'd1);
    r = $urandom_range(0, 19);
    if (r == 0) o.addr = 32'h400 + $urandom_range(0, 255);
    else if (r == 1) o.addr = o.addr | 32'd1;
    o.wdata = $urandom;
    return o;
  endfunction

  initial begin
    #12;
    chk("reset_hreadyout0", 0, 32'(ro0), 1);
    chk("reset_hresp0", 0, 32'(rp0), 0);
    chk("reset_hrdata0", 0, rd0, 0);
    chk("reset_hreadyout1", 0, 32'(ro1), 1);
    chk("reset_hresp1", 0, 32'(rp1), 0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Known contents everywhere so later reads never see uninitialised RAM.
    for (int d = 0; d < 2; d++) begin
      ops.delete();
      for (int w = 0; w < 256; w++)
        ops.push_back(mkop(1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), 32'hC0DE0000 | 32'(w)));
      run_model(1'(d), "init");
    end

    // Zero-wait directed: lanes, bursts, BUSY, errors.
    vec(2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    vec(2'b10, 0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 0);
    vec(2'b10, 1, 3'd0, 32'h13, 32'hAB000000, 32'h0,        2'b00, 0);
    vec(2'b10, 0, 3'd2, 32'h10, 32'h0,        32'hABADBEEF, 2'b00, 0);
    vec(2'b10, 1, 3'd1, 32'h12, 32'h12340000, 32'h0,        2'b00, 0);
    vec(2'b10, 0, 3'd2, 32'h10, 32'h0,        32'h1234BEEF, 2'b00, 0);
    vec(2'b10, 1, 3'd2, 32'h20, 32'd1,        32'h0,        2'b00, 0);
    vec(2'b11, 1, 3'd2, 32'h24, 32'd2,        32'h0,        2'b00, 0);
    vec(2'b11, 1, 3'd2, 32'h28, 32'd3,        32'h0,        2'b00, 0);
    vec(2'b11, 1, 3'd2, 32'h2C, 32'd4,        32'h0,        2'b00, 0);
    vec(2'b10, 0, 3'd2, 32'h28, 32'h0,        32'd3,        2'b00, 0);
    vec(2'b11, 0, 3'd2, 32'h2C, 32'h0,        32'd4,        2'b00, 0);
    vec(2'b11, 0, 3'd2, 32'h20, 32'h0,        32'd1,        2'b00, 0);
    vec(2'b01, 0, 3'd2, 32'h24, 32'h0,        32'h0,        2'b00, 0);
    vec(2'b11, 0, 3'd2, 32'h24, 32'h0,        32'd2,        2'b00, 0);
    vec(2'b10, 1, 3'd2, 32'h400, 32'hFFFFFFFF, 32'h0,       2'b01, 1);
    vec(2'b00, 0, 3'd0, 32'h0,  32'h0,        32'h0,        2'b00, 0);
    vec(2'b10, 1, 3'd1, 32'h01, 32'hFFFFFFFF, 32'h0,        2'b01, 1);
    vec(2'b00, 0, 3'd0, 32'h0,  32'h0,        32'h0,        2'b00, 0);
    vec(2'b10, 1, 3'd3, 32'h00, 32'hFFFFFFFF, 32'h0,        2'b01, 1);
    vec(2'b00, 0, 3'd0, 32'h0,  32'h0,        32'h0,        2'b00, 0);
    vec(2'b10, 0, 3'd2, 32'h00, 32'h0,        32'hC0DE0000, 2'b00, 0);
    run_table(1'b0, "dir_ws0");

    // Two-wait directed.
    vec(2'b10, 1, 3'd2, 32'h40, 32'h55AA, 32'h0,    2'b00, 2);
    vec(2'b10, 0, 3'd2, 32'h40, 32'h0,    32'h55AA, 2'b00, 2);
    vec(2'b10, 1, 3'd2, 32'h44, 32'h11,   32'h0,    2'b00, 2);
    vec(2'b10, 0, 3'd2, 32'h44, 32'h0,    32'h11,   2'b00, 2);
    run_table(1'b1, "dir_ws2");

    // Reset during the first wait cycle of a write must drop the write.
    dsel = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h44;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h77;
    chk("rstwait_low", 0, 32'(ro1), 0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstwait_hreadyout", 0, 32'(ro1), 1);
    chk("rstwait_hresp", 0, 32'(rp1), 0);
    @(posedge HCLK); @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    vec(2'b10, 0, 3'd2, 32'h44, 32'h0, 32'h11, 2'b00, 2);
    run_table(1'b1, "rstwait_read");

    for (int d = 0; d < 2; d++) begin
      ops.delete();
      for (int i = 0; i < 300; i++) ops.push_back(rnd_op());
      run_model(1'(d), d == 0 ? "rnd_ws0" : "rnd_ws2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- Parametrised AHB-Lite memory slave, the next generation of the team's single-port ahb_lite memory block.
- Adds configurable data width, depth and wait states.
- Adds byte/halfword lane writes, an HSEL/HREADY-qualified pipeline, and a two-cycle ERROR response for illegal accesses.
- Sits behind the AHB-Lite decoder/mux as a leaf slave; it is the DUT for the UVM environment.

Parameters:
DATA_WIDTH, 32, data bus width in bits (32 or 64).
DEPTH, 256, number of DATA_WIDTH-bit words; byte capacity = DEPTH*DATA_WIDTH/8.
ADDR_WIDTH, 32, HADDR width.
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
HCLK  input  1  clock, rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from decoder
HADDR  input  ADDR_WIDTH  byte address (address phase)
HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  input  1  1 = write
HSIZE  input  3  0 byte, 1 half, 2 word, 3 dword
HBURST  input  3  burst type (informational; the slave uses HADDR per beat)
HPROT  input  4  ignored, must be accepted
HWDATA  input  DATA_WIDTH  write data (data phase)
HREADY  input  1  bus HREADY (mux output)
HRDATA  output  DATA_WIDTH  read data
HREADYOUT  output  1  slave ready
HRESP  output  2  2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Reset (async, HRESETn=0):
  - HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, pending transfer discarded.
  - Memory array is NOT reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register addr, size, write, valid.
  - IDLE or BUSY (or HSEL=0) while HREADY=1: clears valid; next data phase is zero-wait OKAY with no memory access.
- Legality check at acceptance; ERROR if any of:
  - HADDR >= byte capacity;
  - 8<<HSIZE > DATA_WIDTH;
  - HADDR not aligned to 1<<HSIZE.
- FSM states and transitions:
  - IDLE: legal accept with WAIT_STATES=0 -> DATA; legal accept with WAIT_STATES>0 -> WAIT (counter=WAIT_STATES); illegal accept -> ERR1; otherwise stays IDLE.
  - WAIT: HREADYOUT=0, HRESP=00; decrement each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=00; transfer completes this cycle. A new accept in the same cycle (pipelined) follows the IDLE rules; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. No memory write. A master-driven IDLE accept is legal here (return to IDLE); a new accept follows the IDLE rules.
- Write: in the DATA cycle, bytes selected by size and addr[log2(DATA_WIDTH/8)-1:0] are taken from the matching HWDATA lanes (little-endian) and committed at that rising edge. Other bytes are unchanged.
- Read: during DATA, HRDATA = full word at addr/(DATA_WIDTH/8), driven combinationally from the array. The master selects lanes. HRDATA is 0 outside a read DATA cycle.
- Read-after-write to the same word on consecutive beats returns the new data, because the read data phase follows the write commit edge.
- Wait states apply identically to reads and writes. HWDATA is sampled only in the DATA cycle.
- Reset asserted mid-WAIT/ERR: outputs return to reset values immediately and the pending write is not committed.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then word read @0x10 -> HRDATA=0xDEADBEEF, HRESP=00, HREADYOUT never low.
- Byte write 0xAB @0x13 (HWDATA[31:24]=0xAB), then word read @0x10 -> 0xABADBEEF; halfword write 0x1234 @0x12 -> read 0x1234BEEF.
- INCR4 write @0x20 with data 1,2,3,4 (NONSEQ+3 SEQ, back-to-back); WRAP4 read starting @0x28 -> 3,4,1,2. Insert a BUSY beat -> zero-wait OKAY, data unchanged.
- Error cases, each -> ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01), with memory @0x0 unchanged:
  - write @0x400 (DEPTH=256);
  - halfword @0x01;
  - HSIZE=3 with DATA_WIDTH=32.
- WAIT_STATES=2: word write @0x40 0x55AA then read -> each data phase has exactly 2 HREADYOUT-low cycles; read returns 0x55AA; address is held during wait.
- Assert HRESETn low in the first wait cycle of a write 0x77 @0x44 (prior content 0x11) -> HREADYOUT=1 and HRESP=00 asynchronously; a read after reset returns 0x11.
